// File: rtl/cache_way_select.sv
// ---------------------------------------------------------------------------
// cache_way_select
//
// Tag lookup and way selection for a 4-way set-associative cache. Each set
// holds four {valid, tag} entries and three tree-PLRU bits, all in flops.
// A lookup compares the requested tag against the four ways of its set and
// registers the hit flag, the one-hot hit way (line mux select) and the
// one-hot replacement victim for that set. Responses are held in a single
// output register with a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid           lookup request valid
//   i_req_set, i_req_tag  lookup set index and tag
//   o_req_ready           lookup accepted when high together with i_req_valid
//   o_rsp_valid           response register holds a result
//   i_rsp_ready           downstream consumes the response
//   o_rsp_hit             lookup tag matched a valid way
//   o_rsp_way_sel         one-hot hit way (lowest index on multi-hit), 0 on miss
//   o_rsp_victim          one-hot replacement way for the looked-up set
//   i_fill_valid          write a tag into the array
//   i_fill_set, i_fill_way, i_fill_tag
//                         fill target set, one-hot way and tag
//   i_flush               invalidate every way of every set, clear PLRU
// ---------------------------------------------------------------------------
module cache_way_select #(
   parameter int TAG_BITS = 20,
   parameter int SET_BITS = 6
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_req_valid,
   input  logic [SET_BITS-1:0] i_req_set,
   input  logic [TAG_BITS-1:0] i_req_tag,
   output logic                o_req_ready,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic                o_rsp_hit,
   output logic [3:0]          o_rsp_way_sel,
   output logic [3:0]          o_rsp_victim,
   input  logic                i_fill_valid,
   input  logic [SET_BITS-1:0] i_fill_set,
   input  logic [3:0]          i_fill_way,
   input  logic [TAG_BITS-1:0] i_fill_tag,
   input  logic                i_flush
);

   localparam int NUM_SETS = 1 << SET_BITS;

   // Storage: per-set valid vectors, per-set tree-PLRU bits, per-set/way tags.
   // PLRU bit k of plru_q[s] is tree bit b<k> of set s.
   logic [NUM_SETS-1:0][3:0]               valid_q;
   logic [NUM_SETS-1:0][2:0]               plru_q;
   logic [NUM_SETS-1:0][3:0][TAG_BITS-1:0] tag_q;

   // Response register
   logic       rspValid_q, rspValid_d;
   logic       rspHit_q, rspHit_d;
   logic [3:0] rspWaySel_q, rspWaySel_d;
   logic [3:0] rspVictim_q, rspVictim_d;

   // Lookup datapath
   logic [3:0] setValid;
   logic [2:0] setPlru;
   logic [3:0] match;
   logic       lookupHit;
   logic [3:0] lookupWaySel;
   logic [3:0] lookupVictim;
   logic [1:0] hitIdx;

   // Control
   logic       reqReady;
   logic       accept;
   logic       fillEn;
   logic [1:0] fillIdx;
   logic       hitTouchEn;

   // Keeps only the lowest set bit so a multi-bit vector becomes one-hot.
   function automatic logic [3:0] lowestOneHot(input logic [3:0] v);
      logic [3:0] r;
      r = 4'b0000;
      if (v[0])      r = 4'b0001;
      else if (v[1]) r = 4'b0010;
      else if (v[2]) r = 4'b0100;
      else if (v[3]) r = 4'b1000;
      return r;
   endfunction

   // Index of the lowest set bit; 0 for an all-zero vector (callers gate on that).
   function automatic logic [1:0] lowestIndex(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      if (v[0])      r = 2'd0;
      else if (v[1]) r = 2'd1;
      else if (v[2]) r = 2'd2;
      else if (v[3]) r = 2'd3;
      return r;
   endfunction

   // Tree-PLRU update after way w is used: point the tree away from w.
   // Only the root and the leaf bit of w's pair change.
   function automatic logic [2:0] plruTouch(input logic [2:0] b, input logic [1:0] w);
      logic [2:0] r;
      r = b;
      case (w)
         2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
         2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
         2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
         default: begin r[0] = 1'b0; r[2] = 1'b0; end
      endcase
      return r;
   endfunction

   // Tree-PLRU decode: root picks the pair, the pair's leaf bit picks the way.
   function automatic logic [3:0] plruVictim(input logic [2:0] b);
      logic [3:0] r;
      if (!b[0]) r = b[1] ? 4'b0010 : 4'b0001;
      else       r = b[2] ? 4'b1000 : 4'b0100;
      return r;
   endfunction

   // Tag compare for all four ways of the requested set, using the array
   // contents before any same-cycle fill lands.
   for (genvar w = 0; w < 4; w++) begin : gMatch
      assign match[w] = valid_q[i_req_set][w] && (tag_q[i_req_set][w] == i_req_tag);
   end

   // Hit/victim selection: lowest matching way drives the line mux; an invalid
   // way is always preferred as victim over the PLRU choice.
   always_comb begin
      setValid     = valid_q[i_req_set];
      setPlru      = plru_q[i_req_set];
      lookupHit    = |match;
      lookupWaySel = lowestOneHot(match);
      hitIdx       = lowestIndex(match);
      if (!(&setValid)) lookupVictim = lowestOneHot(~setValid);
      else              lookupVictim = plruVictim(setPlru);
   end

   // Handshake and update enables. A flush blocks new lookups and discards a
   // same-cycle fill. When a fill and an accepted hit touch the same set, the
   // fill's touch is the one kept.
   always_comb begin
      reqReady   = (!rspValid_q || i_rsp_ready) && !i_flush;
      accept     = i_req_valid && reqReady;
      fillEn     = i_fill_valid && (|i_fill_way) && !i_flush;
      fillIdx    = lowestIndex(i_fill_way);
      hitTouchEn = accept && lookupHit && !(fillEn && (i_fill_set == i_req_set));
   end

   // Valid and PLRU state. Flush clears everything; otherwise a fill and a
   // hit touch may update different sets in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         plru_q  <= '0;
      end else if (i_flush) begin
         valid_q <= '0;
         plru_q  <= '0;
      end else begin
         if (fillEn) begin
            valid_q[i_fill_set][fillIdx] <= 1'b1;
            plru_q[i_fill_set]           <= plruTouch(plru_q[i_fill_set], fillIdx);
         end
         if (hitTouchEn) begin
            plru_q[i_req_set] <= plruTouch(plru_q[i_req_set], hitIdx);
         end
      end
   end

   // Tag storage carries no reset; entries are only meaningful once valid.
   always_ff @(posedge i_clk) begin
      if (fillEn) begin
         tag_q[i_fill_set][fillIdx] <= i_fill_tag;
      end
   end

   // Response register next state: load on accept, drop valid once consumed,
   // otherwise hold every field so a stalled consumer sees a stable result.
   always_comb begin
      rspValid_d  = rspValid_q;
      rspHit_d    = rspHit_q;
      rspWaySel_d = rspWaySel_q;
      rspVictim_d = rspVictim_q;
      if (accept) begin
         rspValid_d  = 1'b1;
         rspHit_d    = lookupHit;
         rspWaySel_d = lookupWaySel;
         rspVictim_d = lookupVictim;
      end else if (i_rsp_ready) begin
         rspValid_d = 1'b0;
      end
   end

   // Response register; reset discards a held response immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rspValid_q  <= 1'b0;
         rspHit_q    <= 1'b0;
         rspWaySel_q <= 4'b0000;
         rspVictim_q <= 4'b0000;
      end else begin
         rspValid_q  <= rspValid_d;
         rspHit_q    <= rspHit_d;
         rspWaySel_q <= rspWaySel_d;
         rspVictim_q <= rspVictim_d;
      end
   end

   assign o_req_ready   = reqReady;
   assign o_rsp_valid   = rspValid_q;
   assign o_rsp_hit     = rspHit_q;
   assign o_rsp_way_sel = rspWaySel_q;
   assign o_rsp_victim  = rspVictim_q;

endmodule

// File: doc/cache_way_select.md
CACHE_WAY_SELECT -- requirements
Module: cache_way_select

Interface
REQ-001 Parameter TAG_BITS, default 20, width of the stored and compared tag.
REQ-002 Parameter SET_BITS, default 6, set index width; the number of sets is 2^SET_BITS.
REQ-003 i_clk  input  1  single clock; all state is on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  input  1  lookup request valid.
REQ-006 i_req_set  input  SET_BITS  lookup set index.
REQ-007 i_req_tag  input  TAG_BITS  lookup tag.
REQ-008 o_req_ready  output  1  lookup accepted this cycle when high together with i_req_valid.
REQ-009 o_rsp_valid  output  1  response register holds a result.
REQ-010 i_rsp_ready  input  1  downstream consumes the response.
REQ-011 o_rsp_hit  output  1  lookup tag matched a valid way.
REQ-012 o_rsp_way_sel  output  4  one-hot hit way, driving the 4:1 line mux select; 4'b0000 on miss.
REQ-013 o_rsp_victim  output  4  one-hot replacement way for the looked-up set.
REQ-014 i_fill_valid  input  1  write a tag into the array.
REQ-015 i_fill_set  input  SET_BITS  fill set index.
REQ-016 i_fill_way  input  4  one-hot fill way.
REQ-017 i_fill_tag  input  TAG_BITS  fill tag.
REQ-018 i_flush  input  1  invalidate all ways of all sets.

Function
REQ-019 Storage: per set and way, one valid bit plus a TAG_BITS tag; per set, 3 tree-PLRU bits b[2:0]; all held in flops.
REQ-020 Handshake: o_req_ready = (!o_rsp_valid | i_rsp_ready) & !i_flush.
REQ-021 A request is accepted when i_req_valid & o_req_ready; its result is registered and o_rsp_valid is high on the next edge (1-cycle latency).
REQ-022 Response fields hold stable while o_rsp_valid & !i_rsp_ready.
REQ-023 o_rsp_valid clears on the edge where i_rsp_ready is high and no new request is accepted.
REQ-024 Hit: way w matches when valid[set][w] & tag[set][w]==i_req_tag; o_rsp_hit = OR of matches.
REQ-025 If more than one way matches, o_rsp_way_sel is the lowest-index match only; it is never multi-hot.
REQ-026 Victim: the lowest-index invalid way if any way in the set is invalid; otherwise the PLRU way.
REQ-027 PLRU decode: b0=0 selects the pair {0,1}, else the pair {2,3}; b1=0 selects way0, else way1; b2=0 selects way2, else way3.
REQ-028 PLRU touch of way w: w0 sets b0=1,b1=1; w1 sets b0=1,b1=0; w2 sets b0=0,b2=1; w3 sets b0=0,b2=0; untouched bits keep their values.
REQ-029 An accepted hit touches the hit way of its set on the accept edge; a miss leaves PLRU unchanged.
REQ-030 Fill writes the tag, sets valid and touches i_fill_way in i_fill_set on the edge; a zero i_fill_way is a no-op.
REQ-031 A multi-hot i_fill_way writes only the lowest-index set bit.
REQ-032 A lookup in the same cycle as a fill to the same set uses the pre-fill contents.
REQ-033 On a same-set PLRU conflict, the fill touch wins and the hit touch is dropped.
REQ-034 Flush clears every valid bit and every PLRU bit on the edge.
REQ-035 Flush has priority over a same-cycle fill, which is discarded.
REQ-036 Flush does not disturb a response already held in the response register.

Reset
REQ-037 While i_rst_n=0: all valid and PLRU bits are 0; o_rsp_valid=0, o_rsp_hit=0, o_rsp_way_sel=4'b0000, o_rsp_victim=4'b0000.
REQ-038 Tags are don't-care after reset.
REQ-039 Reset asserted mid-transaction discards the held response immediately (asynchronous).
REQ-040 Operation resumes on the first rising edge after i_rst_n deasserts.

Verification
REQ-041 Reset, then lookup set 5 tag 0x123 -> next cycle o_rsp_valid=1, hit=0, way_sel=0000, victim=0001.
REQ-042 Fill set 5 way 0100 tag 0x123, then lookup set 5 tag 0x123 -> hit=1, way_sel=0100; PLRU of set 5 becomes b0=0, b2=1.
REQ-043 Fill all four ways of set 3 in order 0,1,2,3, then lookup a missing tag -> victim=0001; after a hit on way0, the next miss gives victim=0100.
REQ-044 Hold i_rsp_ready=0 for 3 cycles with i_req_valid=1 -> o_req_ready=0 and response fields stable; release -> one accept per cycle, back-to-back responses.
REQ-045 Same-cycle fill and lookup on set 7, same tag -> lookup reports miss; the following lookup reports a hit.
REQ-046 Flush while fills and lookups are in flight, then lookup any previously filled tag -> hit=0 and victim=0001.
